// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared single-precision definitions for the FPU datapath blocks.
//   fp32_t      : IEEE-754 single-precision field view {sign, exp, man}
//   FP_EXP_MAX  : all-ones exponent (infinity / NaN encoding)
//   FP_BIAS     : exponent bias
// -----------------------------------------------------------------------------
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam logic [7:0] FP_EXP_MAX = 8'd255;
    localparam int         FP_BIAS    = 127;

endpackage

// File: rtl/fmul_unit_if.sv
// -----------------------------------------------------------------------------
// fmul_unit_if
// Request/response handshake bundle between FPU dispatch / write-back and
// fmul_unit.
//   req_*  : dispatch -> unit request channel (valid/ready, operands, tag)
//   resp_* : unit -> write-back response channel (valid/ready, result, tag, ovf)
// Modports:
//   master : the dispatch / write-back side
//   slave  : fmul_unit
// -----------------------------------------------------------------------------
interface fmul_unit_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_x1;
    logic [31:0]      req_x2;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_y;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_ovf;

    modport master (
        output req_valid, req_x1, req_x2, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_y, resp_tag, resp_ovf
    );

    modport slave (
        input  req_valid, req_x1, req_x2, req_tag, resp_ready,
        output req_ready, resp_valid, resp_y, resp_tag, resp_ovf
    );
endinterface

// File: rtl/fmul.sv
// -----------------------------------------------------------------------------
// fmul
// Combinational single-precision multiplier, round-to-nearest-even.
// Subnormal inputs and underflowing results are flushed to signed zero.
//   x1, x2 : operands (IEEE-754 single)
//   y      : product
//   ovf    : product exponent exceeded the finite range (y is +/-inf)
// -----------------------------------------------------------------------------
module fmul
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);
    fp32_t       a, b;
    logic        sign;
    logic [23:0] ma, mb;
    logic [47:0] prod;
    logic        norm_hi;
    logic [22:0] mant;
    logic        grd, stk, rnd;
    logic [23:0] mant_r;
    logic [9:0]  e_sum;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign a = x1;
    assign b = x2;

    always_comb begin
        sign    = a.sign ^ b.sign;
        ma      = {1'b1, a.man};
        mb      = {1'b1, b.man};
        prod    = {24'b0, ma} * {24'b0, mb};
        norm_hi = prod[47];
        mant    = norm_hi ? prod[46:24] : prod[45:23];
        grd     = norm_hi ? prod[23] : prod[22];
        stk     = norm_hi ? (|prod[22:0]) : (|prod[21:0]);
        rnd     = grd && (stk || mant[0]);
        mant_r  = {1'b0, mant} + 24'(rnd);
        // Biased sum of both exponents; rounding carry bumps it by one.
        e_sum   = {2'b0, a.exp} + {2'b0, b.exp} + 10'(norm_hi) + 10'(mant_r[23]);

        a_nan  = (a.exp == FP_EXP_MAX) && (a.man != '0);
        b_nan  = (b.exp == FP_EXP_MAX) && (b.man != '0);
        a_inf  = (a.exp == FP_EXP_MAX) && (a.man == '0);
        b_inf  = (b.exp == FP_EXP_MAX) && (b.man == '0);
        a_zero = (a.exp == 8'd0);
        b_zero = (b.exp == 8'd0);

        y   = '0;
        ovf = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            y = {1'b0, FP_EXP_MAX, 23'h400000};
        end else if (a_inf || b_inf) begin
            y = {sign, FP_EXP_MAX, 23'h0};
        end else if (a_zero || b_zero) begin
            y = {sign, 31'h0};
        end else if (e_sum >= (10'(FP_EXP_MAX) + 10'(FP_BIAS))) begin
            y   = {sign, FP_EXP_MAX, 23'h0};
            ovf = 1'b1;
        end else if (e_sum <= 10'(FP_BIAS)) begin
            y = {sign, 31'h0};
        end else begin
            y = {sign, 8'(e_sum - 10'(FP_BIAS)), mant_r[22:0]};
        end
    end
endmodule

// File: rtl/fmul_req_fifo.sv
// -----------------------------------------------------------------------------
// fmul_req_fifo
// Synchronous FIFO with registered count/full/empty and combinational head.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (drops contents, ignores same-edge push)
//   push     : write wdata (ignored when full)
//   pop      : drop head entry (ignored when empty)
//   rdata    : current head entry
//   count    : number of held entries
//   full     : count == DEPTH
//   empty    : count == 0
// -----------------------------------------------------------------------------
module fmul_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;
    logic          push_ok, pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage needs no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push_ok && !clr && !rst) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;
endmodule

// File: rtl/fmul_unit.sv
// -----------------------------------------------------------------------------
// fmul_unit
// Flow-controlled front end for fmul: request FIFO -> S1 operand register ->
// fmul -> S2 result register -> response port. In-order, no drops.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : fmul_unit_if.slave request/response handshakes
//   ovf_clear  : clears ovf_sticky (a same-cycle overflow handshake wins)
//   ovf_sticky : set by any overflowing response handshake
//   busy       : any request held in FIFO, S1 or S2
//   flush      : only with FMUL_UNIT_FLUSH_EN; drops all in-flight requests
// -----------------------------------------------------------------------------
module fmul_unit
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    fmul_unit_if.slave  bus,
    input  logic        ovf_clear,
    output logic        ovf_sticky,
`ifdef FMUL_UNIT_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy
);
    localparam int EW = 64 + TAG_W;
    localparam int CW = $clog2(DEPTH + 1);

    logic flush_w;
`ifdef FMUL_UNIT_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic [EW-1:0]    fifo_head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic             push, pop, adv1, adv2;
    fp32_t            head_x1, head_x2;
    logic [TAG_W-1:0] head_tag;

    logic             s1_valid_q, s1_valid_d;
    fp32_t            s1_x1_q, s1_x1_d, s1_x2_q, s1_x2_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_y_q, s2_y_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             ovf_sticky_q, ovf_sticky_d;
    logic [31:0]      mul_y;
    logic             mul_ovf;

    assign adv2 = !s2_valid_q || bus.resp_ready;
    assign adv1 = !s1_valid_q || adv2;
    assign pop  = adv1 && !fifo_empty;
    // fifo_full is registered, so req_ready never sees a same-cycle pop.
    assign push = bus.req_valid && !fifo_full;

    fmul_req_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush_w),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.req_x1, bus.req_x2, bus.req_tag}),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_x1, head_x2, head_tag} = fifo_head;

    fmul u_fmul (
        .x1  (s1_x1_q),
        .x2  (s1_x2_q),
        .y   (mul_y),
        .ovf (mul_ovf)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x1_d    = s1_x1_q;
        s1_x2_d    = s1_x2_q;
        s1_tag_d   = s1_tag_q;
        if (adv1) begin
            s1_valid_d = !fifo_empty;
            if (!fifo_empty) begin
                s1_x1_d  = head_x1;
                s1_x2_d  = head_x2;
                s1_tag_d = head_tag;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        s2_ovf_d   = s2_ovf_q;
        s2_tag_d   = s2_tag_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            s2_y_d     = mul_y;
            s2_ovf_d   = mul_ovf;
            s2_tag_d   = s1_tag_q;
        end

        ovf_sticky_d = ovf_sticky_q;
        if (s2_valid_q && bus.resp_ready && s2_ovf_q) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_x1_q      <= '0;
            s1_x2_q      <= '0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_y_q       <= '0;
            s2_ovf_q     <= 1'b0;
            s2_tag_q     <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            s1_valid_q   <= flush_w ? 1'b0 : s1_valid_d;
            s1_x1_q      <= s1_x1_d;
            s1_x2_q      <= s1_x2_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= flush_w ? 1'b0 : s2_valid_d;
            s2_y_q       <= s2_y_d;
            s2_ovf_q     <= s2_ovf_d;
            s2_tag_q     <= s2_tag_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign bus.req_ready  = !fifo_full;
    assign bus.resp_valid = s2_valid_q;
    assign bus.resp_y     = s2_y_q;
    assign bus.resp_tag   = s2_tag_q;
    assign bus.resp_ovf   = s2_ovf_q;
    assign ovf_sticky     = ovf_sticky_q;
    assign busy           = (fifo_count != '0) || s1_valid_q || s2_valid_q;
endmodule

// File: doc/fmul_unit.md
# fmul_unit

Pipelined, flow-controlled front end for the combinational single-precision multiplier `fmul`. It accepts tagged multiply requests from the FPU dispatch stage through a valid/ready handshake and buffers them in a small request FIFO. It registers operands into `fmul`, registers the result together with its overflow flag, and returns tagged responses in request order to the FPU write-back stage. It also keeps a sticky overflow flag for the FPU status register.

## Interface
- `TAG_W`, default 5: width of the request/response tag.
- `DEPTH`, default 4: request FIFO entries; power of two, ≥2.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request this cycle.
- `req_x1`, `req_x2`  in  32: IEEE-754 single operands.
- `req_tag`  in  TAG_W: request tag, returned unchanged.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_y`  out  32: `fmul` result.
- `resp_tag`  out  TAG_W: tag of this response.
- `resp_ovf`  out  1: `fmul` overflow flag for this response.
- `ovf_sticky`  out  1: accumulated overflow flag.
- `ovf_clear`  in  1: clears `ovf_sticky`.
- `busy`  out  1: any entry is held in the FIFO, S1 or S2.

## Operation
- Path: request FIFO → S1 operand register (x1, x2, tag, valid) → `fmul` (combinational) → S2 result register (y, ovf, tag, valid) → response port.
- Request accept: `req_valid && req_ready` at a rising edge pushes {x1, x2, tag}.
- `req_ready` is `count != DEPTH`. It depends on registered state only, never on same-cycle pops or `resp_ready`.
- S2 advance (`adv2`): `!s2_valid || resp_ready`. S2 loads S1 and takes S2 valid from S1 valid.
- S1 advance (`adv1`): `!s1_valid || adv2`. S1 loads the FIFO head when the FIFO is non-empty; otherwise S1 valid goes to 0.
- FIFO pop occurs exactly when `adv1` is true and `count != 0`.
- A stalled stage holds all of its fields unchanged.
- Responses leave in acceptance order. There is no reordering and no dropping.
- Push and pop in the same cycle leave `count` unchanged. Read and write pointers wrap modulo DEPTH.
- Total buffering is DEPTH+2 requests. With a stalled consumer, DEPTH+2 requests are accepted before `req_ready` falls.
- `ovf_sticky` is set on a response handshake (`resp_valid && resp_ready && resp_ovf`) and cleared on `ovf_clear`. When both occur in the same cycle, set wins.
- Operands with exponent 0 or 255 are passed to `fmul` unchanged. The unit adds no special-case handling.

## Timing
- Reset values: `req_ready` 1, `resp_valid` 0, `resp_y` 0, `resp_tag` 0, `resp_ovf` 0, `ovf_sticky` 0, `busy` 0. Count, pointers, S1 and S2 valids are all 0.
- Reset mid-operation discards every in-flight request and gives no responses for them.
- Latency on an empty unit with `resp_ready=1`: a request accepted at edge E0 enters S1 at E1 and S2 at E2. `resp_valid` is high in the cycle after E2, i.e. 2 cycles.
- Throughput is 1 request per cycle while `resp_ready` stays high.
- `resp_*` outputs are driven directly from S2 registers, with no combinational path from the `req_*` inputs.

## Configuration
- `FMUL_UNIT_FLUSH_EN` defined: adds input port `flush` (1 bit).
  - When `flush` is high at an edge, count, pointers, S1 valid and S2 valid clear, and any push that edge is ignored.
  - `ovf_sticky` is kept.
  - Flush has lower priority than `rst`.
- `FMUL_UNIT_FLUSH_EN` undefined: the `flush` port and its logic are absent.

## Structure
- Shared package `fpu_pkg` holds:
  - `fp32_t` packed struct {sign, exp[7:0], man[22:0]};
  - constants `FP_EXP_MAX` = 8'd255 and `FP_BIAS` = 127.
- `fmul` is instantiated unmodified as the datapath.
- One new sub-module, `fmul_req_fifo`: synchronous FIFO parameterised by width and DEPTH. It has registered count, full and empty, and a combinational head read.

## Test plan
- Single op, tag 3:
  - stimulus: 0x3FC00000 × 0x40000000;
  - expected: `resp_y`=0x40400000, tag 3, `resp_ovf`=0, `resp_valid` exactly 2 cycles after accept.
- Overflow:
  - stimulus: 0x7F000000 × 0x7F000000;
  - expected: `resp_ovf`=1; `ovf_sticky` rises the cycle after the handshake and stays high until `ovf_clear`.
- Backpressure, `resp_ready`=0:
  - stimulus: 7 back-to-back requests with tags 0–6;
  - expected: tags 0–5 accepted, `req_ready` low for the 7th.
  - Then raise `resp_ready`: responses arrive with tags 0–5 in order on consecutive cycles, and tag 6 is accepted the cycle after the first pop.
- Set/clear collision:
  - stimulus: `ovf_clear`=1 in the same cycle as an overflowing response handshake;
  - expected: `ovf_sticky`=1.
- Reset mid-stream:
  - stimulus: assert `rst` with 3 requests in flight;
  - expected: next cycle `resp_valid`=0, `busy`=0, `req_ready`=1; the next request behaves like the single-op case.
- With `FMUL_UNIT_FLUSH_EN`:
  - stimulus: flush with a full unit;
  - expected: `busy`=0 next cycle, no stale responses, `ovf_sticky` unchanged.
